// File: rtl/keypad_emulator_if.sv
// -----------------------------------------------------------------------------
// keypad_emulator_if
// Request/status bundle between a press sequencer (master) and the keypad
// emulator (slave).
//   press_req    master -> slave  one-cycle request to start a key press
//   key_code     master -> slave  key to press (0-9, 10 = '*', 11 = '#')
//   hold_cycles  master -> slave  stable-closed duration (0 behaves as 1)
//   busy         slave -> master  press sequence in progress
//   done         slave -> master  one-cycle pulse when a sequence completes
//   err          slave -> master  one-cycle pulse when a request is rejected
//   press_count  slave -> master  completed presses, wraps at 256
// -----------------------------------------------------------------------------
interface keypad_emulator_if;
    logic        press_req;
    logic [3:0]  key_code;
    logic [15:0] hold_cycles;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  press_count;

    modport master (
        output press_req, key_code, hold_cycles,
        input  busy, done, err, press_count
    );

    modport slave (
        input  press_req, key_code, hold_cycles,
        output busy, done, err, press_count
    );
endinterface

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
// Emulates a 4x3 matrix keypad key press, including contact bounce on press
// and release, for exercising a keypad scanner.
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   ctrl          request/status bundle (keypad_emulator_if.slave)
//   B, G, F, D    row drives from the scanner (row0..row3), active-high
//   A, C, E       column senses to the scanner (col0..col2), active-high
// -----------------------------------------------------------------------------
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_TOGGLE = 8,
    parameter int RELEASE_GAP   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    keypad_emulator_if.slave         ctrl,
    input  logic                     B,
    input  logic                     G,
    input  logic                     F,
    input  logic                     D,
    output logic                     A,
    output logic                     C,
    output logic                     E
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_BOUNCE_IN  = 3'd1;
    localparam logic [2:0] S_HOLD       = 3'd2;
    localparam logic [2:0] S_BOUNCE_OUT = 3'd3;
    localparam logic [2:0] S_GAP        = 3'd4;

    // Terminal counts; all duration counters count 0..N-1.
    localparam logic [15:0] BOUNCE_LAST = (BOUNCE_CYCLES > 0) ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
    localparam logic [15:0] TOGGLE_LAST = (BOUNCE_TOGGLE > 1) ? 16'(BOUNCE_TOGGLE - 1) : 16'd0;
    localparam logic [15:0] GAP_LAST    = (RELEASE_GAP > 0)   ? 16'(RELEASE_GAP - 1)   : 16'd0;
    localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES > 0);

    logic [2:0]  state;
    logic        contact;
    logic [3:0]  key_lat;
    logic [15:0] hold_last;
    logic [15:0] cnt;
    logic [15:0] tcnt;
    logic        err_q;
    logic [7:0]  count_q;

    logic [3:0]  row_sel;
    logic [2:0]  col_sel;
    logic        row_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            contact   <= 1'b0;
            key_lat   <= 4'd0;
            hold_last <= 16'd0;
            cnt       <= 16'd0;
            tcnt      <= 16'd0;
            err_q     <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctrl.press_req) begin
                        if (ctrl.key_code <= 4'd11) begin
                            key_lat   <= ctrl.key_code;
                            // Store hold-1 so a request of 0 or 1 both give one cycle.
                            hold_last <= (ctrl.hold_cycles == 16'd0) ? 16'd0
                                                                     : ctrl.hold_cycles - 16'd1;
                            contact   <= 1'b1;
                            cnt       <= 16'd0;
                            tcnt      <= 16'd0;
                            state     <= HAS_BOUNCE ? S_BOUNCE_IN : S_HOLD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_BOUNCE_IN, S_BOUNCE_OUT: begin
                    if (cnt == BOUNCE_LAST) begin
                        // End of window: force the settled level regardless of toggle phase.
                        contact <= (state == S_BOUNCE_IN);
                        cnt     <= 16'd0;
                        state   <= (state == S_BOUNCE_IN) ? S_HOLD : S_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (tcnt == TOGGLE_LAST) begin
                            tcnt    <= 16'd0;
                            contact <= ~contact;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt == hold_last) begin
                        contact <= 1'b0;
                        cnt     <= 16'd0;
                        tcnt    <= 16'd0;
                        state   <= HAS_BOUNCE ? S_BOUNCE_OUT : S_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt     <= 16'd0;
                        count_q <= count_q + 8'd1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    contact <= 1'b0;
                end
            endcase
        end
    end

    // Matrix position of the latched key: row_sel bit r = row r, col_sel bit c = col c.
    always_comb begin
        row_sel = 4'b0000;
        col_sel = 3'b000;
        case (key_lat)
            4'd1:    begin row_sel = 4'b0001; col_sel = 3'b001; end
            4'd2:    begin row_sel = 4'b0001; col_sel = 3'b010; end
            4'd3:    begin row_sel = 4'b0001; col_sel = 3'b100; end
            4'd4:    begin row_sel = 4'b0010; col_sel = 3'b001; end
            4'd5:    begin row_sel = 4'b0010; col_sel = 3'b010; end
            4'd6:    begin row_sel = 4'b0010; col_sel = 3'b100; end
            4'd7:    begin row_sel = 4'b0100; col_sel = 3'b001; end
            4'd8:    begin row_sel = 4'b0100; col_sel = 3'b010; end
            4'd9:    begin row_sel = 4'b0100; col_sel = 3'b100; end
            4'd10:   begin row_sel = 4'b1000; col_sel = 3'b001; end
            4'd0:    begin row_sel = 4'b1000; col_sel = 3'b010; end
            4'd11:   begin row_sel = 4'b1000; col_sel = 3'b100; end
            default: begin row_sel = 4'b0000; col_sel = 3'b000; end
        endcase
    end

    // Combinational path from row drives so the scanner sees the column in the same cycle.
    assign row_hit = contact & |(row_sel & {D, F, G, B});
    assign A = row_hit & col_sel[0];
    assign C = row_hit & col_sel[1];
    assign E = row_hit & col_sel[2];

    assign ctrl.busy        = (state != S_IDLE);
    assign ctrl.done        = (state == S_GAP) && (cnt == GAP_LAST);
    assign ctrl.err         = err_q;
    assign ctrl.press_count = count_q;

endmodule
